// File: rtl/bram_pkg.sv
// Shared definitions for the synchronous block RAM family.
// Holds write-mode encodings and the legal read-latency bounds.
package bram_pkg;

    // Output behaviour of the port during a write access.
    localparam int BRAM_READ_FIRST  = 0;
    localparam int BRAM_WRITE_FIRST = 1;
    localparam int BRAM_NO_CHANGE   = 2;

    localparam int BRAM_MIN_READ_LATENCY = 1;
    localparam int BRAM_MAX_READ_LATENCY = 4;

    function automatic bit bram_mode_legal(input int mode);
        return (mode >= BRAM_READ_FIRST) && (mode <= BRAM_NO_CHANGE);
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Valid-qualified register chain extending the RAM read latency.
// Ports: clk, rst_n, in_data/in_valid (stage 0), out_data/out_valid.
module bram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    if (STAGES == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = clk ^ rst_n;
        assign out_data      = in_data;
        assign out_valid     = in_valid;
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] data_d [STAGES];
        logic [DATA_WIDTH-1:0] data_q [STAGES];
        logic [STAGES-1:0]     valid_d;
        logic [STAGES-1:0]     valid_q;

        // Data only advances behind a valid word, so the tail
        // holds the last returned word; valid shifts every cycle.
        always_comb begin
            data_d     = data_q;
            valid_d    = '0;
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = in_data;
            end
            for (int s = 1; s < STAGES; s++) begin
                valid_d[s] = valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_d[s] = data_q[s-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < STAGES; s++) begin
                    data_q[s] <= '0;
                end
                valid_q <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign out_data  = data_q[STAGES-1];
        assign out_valid = valid_q[STAGES-1];
    end

endmodule

// File: rtl/bram_sync_sp_be.sv
// Single-port synchronous RAM with byte-lane write enables,
// selectable read-during-write mode and a pipelined read path.
// Ports: clk, rst_n (async, active-low); en/wr/be/addr/data_in
// access; data_out/data_valid returned READ_LATENCY cycles later.
module bram_sync_sp_be
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             wr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH-1:0]            data_in,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             data_valid
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY < BRAM_MIN_READ_LATENCY ||
        READ_LATENCY > BRAM_MAX_READ_LATENCY) begin : g_bad_lat
        $error("READ_LATENCY out of range 1..4");
    end
    if (!bram_mode_legal(WRITE_MODE)) begin : g_bad_mode
        $error("WRITE_MODE must be 0..2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] new_word;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_d;
    logic                  rd_valid_q;

    // Accesses seen while reset is held are dropped, writes included.
    always_comb begin
        mem_we   = en && wr && rst_n;
        old_word = mem[addr];
        new_word = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) begin
                new_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                    data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Array has no reset so it stays inferable as block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be[i]) begin
                    mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Stage 0 loads only when the access returns a word.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (en) begin
            if (!wr) begin
                rd_valid_d = 1'b1;
                rd_data_d  = old_word;
            end else begin
                case (WRITE_MODE)
                    BRAM_READ_FIRST: begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = old_word;
                    end
                    BRAM_WRITE_FIRST: begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = new_word;
                    end
                    default: begin
                        rd_valid_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    bram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (READ_LATENCY - 1)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (rd_data_q),
        .in_valid  (rd_valid_q),
        .out_data  (data_out),
        .out_valid (data_valid)
    );

endmodule

// File: tb/tb_bram_sync_sp_be.sv
// Scoreboard bench: one DUT per (WRITE_MODE, READ_LATENCY) pair,
// all driven by the same stimulus and checked against a word model.
module tb_bram_sync_sp_be;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        wr    = 1'b0;
    logic [3:0]  be    = '0;
    logic [9:0]  addr  = '0;
    logic [31:0] data_in = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit done     = 1'b0;

    // Reference memory and the access pending for the next edge.
    logic [31:0] mref [16];
    bit          p_en  = 1'b0;
    bit          p_wr  = 1'b0;
    logic [31:0] p_old = '0;
    logic [31:0] p_new = '0;
    int          p_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input bit ok, input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] d,
                                          input logic [3:0]  b);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    for (genvar m = 0; m < 3; m++) begin : g_m
        for (genvar l = 1; l <= 4; l++) begin : g_l
            logic [31:0] dout;
            logic        dv;
            exp_t        q[$];
            logic [31:0] last = '0;

            bram_sync_sp_be #(
                .DATA_WIDTH   (32),
                .ADDR_WIDTH   (10),
                .BYTE_WIDTH   (8),
                .READ_LATENCY (l),
                .WRITE_MODE   (m)
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (en),
                .wr         (wr),
                .be         (be),
                .addr       (addr),
                .data_in    (data_in),
                .data_out   (dout),
                .data_valid (dv)
            );

            // Expected response recorded when the access is accepted.
            always @(posedge clk) begin
                if (rst_n && p_en) begin
                    if (!p_wr) q.push_back('{p_old, p_cyc + l});
                    else if (m == 0) q.push_back('{p_old, p_cyc + l});
                    else if (m == 1) q.push_back('{p_new, p_cyc + l});
                end
            end

            always @(negedge clk) begin
                if (!rst_n) begin
                    check(dout == 32'h0 && !dv,
                          $sformatf("m%0d_l%0d_rst_state", m, l),
                          dout, 32'h0);
                end else if (dv) begin
                    if (q.size() == 0) begin
                        check(1'b0,
                              $sformatf("m%0d_l%0d_unexpected_valid", m, l),
                              dout, last);
                        last = dout;
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check(cyc == e.due,
                              $sformatf("m%0d_l%0d_latency", m, l),
                              cyc, e.due);
                        check(dout === e.data,
                              $sformatf("m%0d_l%0d_data", m, l),
                              dout, e.data);
                        last = e.data;
                    end
                end else begin
                    check(dout === last,
                          $sformatf("m%0d_l%0d_hold", m, l), dout, last);
                    if (q.size() > 0 && q[0].due <= cyc) begin
                        check(1'b0,
                              $sformatf("m%0d_l%0d_missing_valid", m, l),
                              dv, 1);
                        void'(q.pop_front());
                    end
                end
            end

            // In-flight reads die with reset; outputs clear at once.
            always @(negedge rst_n) begin
                q.delete();
                last = '0;
                if (cyc > 0) begin
                    #1;
                    check(dout == 32'h0 && !dv,
                          $sformatf("m%0d_l%0d_rst_now", m, l),
                          dout, 32'h0);
                end
            end

            always @(posedge done) begin
                check(q.size() == 0,
                      $sformatf("m%0d_l%0d_drained", m, l),
                      q.size(), 0);
            end
        end
    end

    task automatic drive(input bit e, input bit w, input logic [3:0] b,
                         input logic [3:0] a, input logic [31:0] d);
        en      = e;
        wr      = w;
        be      = b;
        addr    = {6'd0, a};
        data_in = d;
        p_en    = e;
        p_wr    = w;
        p_cyc   = cyc;
        p_old   = mref[a];
        p_new   = merge(mref[a], d, b);
        if (e && w && rst_n) mref[a] = p_new;
    endtask

    task automatic access(input bit e, input bit w, input logic [3:0] b,
                          input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(e, w, b, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(0, 0, 4'h0, 4'h0, $urandom);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        drive(0, 0, 4'h0, 4'h0, 32'h0);
        #2;
        rst_n = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 4'hF, 4'd6, 32'hDEADBEEF);
        access(1, 0, 4'h0, 4'd6, 32'h0);
        idle(5);
        for (int a = 0; a < 16; a++) begin
            if (a != 6) access(1, 1, 4'hF, a[3:0], $urandom);
        end
        access(1, 1, 4'hF, 4'd3, 32'h11223344);
        access(1, 1, 4'b0101, 4'd3, 32'hAABBCCDD);
        access(1, 0, 4'h0, 4'd3, 32'h0);
        access(1, 1, 4'hF, 4'd5, 32'h0);
        idle(5);
        access(1, 1, 4'hC, 4'd5, 32'hFFFF0000);
        idle(5);
        access(1, 0, 4'h0, 4'd5, 32'h0);
        access(1, 1, 4'h0, 4'd5, 32'h12345678);
        access(1, 0, 4'h0, 4'd5, 32'h0);
        idle(3);
        for (int a = 0; a < 16; a++) access(1, 0, 4'h0, a[3:0], $urandom);
        idle(8);
        for (int i = 0; i < 400; i++) begin
            access($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                   (i % 7 == 0) ? 4'h0 : 4'($urandom),
                   4'($urandom), $urandom);
        end
        access(1, 0, 4'h0, 4'd2, 32'h0);
        access(1, 0, 4'h0, 4'd9, 32'h0);
        assert_reset();
        for (int i = 0; i < 3; i++) begin
            access(1, 1, 4'hF, 4'(i), 32'hBAD0BAD0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 4'h0, 4'd0, 32'h0);
        for (int a = 1; a < 16; a++) access(1, 0, 4'h0, a[3:0], 32'h0);
        idle(8);
        done = 1'b1;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
